// File: rtl/serial_sub.sv
// Bit-serial subtractor: computes a-b LSB first, one bit per clock, via a one-bit
// borrow cell. Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       w_cell;
  logic             w_accept;
  logic             w_last;

  // One-bit subtractor cell: returns {borrow_out, difference}.
  function automatic logic [1:0] sub_cell(input logic ai, input logic bi, input logic bri);
    logic d;
    logic bo;
    d  = ai ^ bi ^ bri;
    bo = (~ai & bi) | (~(ai ^ bi) & bri);
    return {bo, d};
  endfunction

  assign w_cell   = sub_cell(r_a[0], r_b[0], r_br);
  assign w_accept = start & (r_state != SHIFT);
  assign w_last   = (r_cnt == LAST);
  assign diff     = r_diff;
  assign borrow   = r_br;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_accept ? SHIFT : IDLE;
      SHIFT:   w_next = w_last ? DONE : SHIFT;
      DONE:    w_next = w_accept ? SHIFT : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Status outputs decoded from the registered state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      IDLE:    begin busy = 1'b0; done = 1'b0; end
      SHIFT:   begin busy = 1'b1; done = 1'b0; end
      DONE:    begin busy = 1'b0; done = 1'b1; end
      default: begin busy = 1'b0; done = 1'b0; end
    endcase
  end

  // Operand shift registers, borrow, bit counter and result; diff fills from the MSB side
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_diff <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_a    <= a;
      r_b    <= b;
      r_br   <= 1'b0;
      r_cnt  <= '0;
    end else if (r_state == SHIFT) begin
      r_a    <= {1'b0, r_a[WIDTH-1:1]};
      r_b    <= {1'b0, r_b[WIDTH-1:1]};
      r_diff <= {w_cell[0], r_diff[WIDTH-1:1]};
      r_br   <= w_cell[1];
      r_cnt  <= r_cnt + CW'(1);
    end else begin
      r_a    <= r_a;
      r_b    <= r_b;
      r_diff <= r_diff;
      r_br   <= r_br;
      r_cnt  <= r_cnt;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic r_ovf;
  assign ovf = r_ovf;

  // On the final bit the operand MSBs sit at bit 0 and the cell output is the result MSB
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if ((r_state == SHIFT) && w_last && !w_accept) begin
      r_ovf <= (r_a[0] ^ r_b[0]) & (r_a[0] ^ w_cell[0]);
    end else begin
      r_ovf <= r_ovf;
    end
  end
`endif

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub (WIDTH=8): directed vectors push expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_serial_sub;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf;
`endif

  serial_sub #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       br;
    logic       ov;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   cyc        = 0;
  int   vectors    = 0;
  int   miscompares = 0;

  // Edge counter: at a negedge, cyc equals the number of posedges so far
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got done=1, expected none (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("diff", {24'd0, diff}, {24'd0, e.d});
        chk("borrow", {31'd0, borrow}, {31'd0, e.br});
        chk("done_cycle", cyc, e.due);
        chk("busy_in_done", {31'd0, busy}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf", {31'd0, ovf}, {31'd0, e.ov});
`endif
      end
    end
  end

  task automatic push_exp(input logic [7:0] d, input logic br, input logic ov, input int due);
    exp_t e;
    e.d = d; e.br = br; e.ov = ov; e.due = due;
    sb.push_back(e);
  endtask

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic [7:0] ed, input logic eb, input logic eo);
    @(negedge clk);
    start = 1'b1; a = ta; b = tb_v;
    push_exp(ed, eb, eo, cyc + 9);
    @(negedge clk);
    start = 1'b0; a = ~ta; b = ~tb_v;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    repeat (9) @(negedge clk);
    chk("diff_hold", {24'd0, diff}, {24'd0, ed});
    chk("borrow_hold", {31'd0, borrow}, {31'd0, eb});
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_done", {31'd0, done}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_diff", {24'd0, diff}, 32'd0);
    chk("rst_borrow", {31'd0, borrow}, 32'd0);
    rst = 1'b0;

    run_op(8'd5,  8'd3,  8'h02, 1'b0, 1'b0);
    run_op(8'd3,  8'd5,  8'hFE, 1'b1, 1'b0);
    run_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
    run_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    run_op(8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0);
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);

    // start pulsed in the third SHIFT cycle must be ignored
    @(negedge clk);
    start = 1'b1; a = 8'd5; b = 8'd3;
    push_exp(8'h02, 1'b0, 1'b0, cyc + 9);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; a = 8'h77; b = 8'h11;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);

    // reset in the fourth SHIFT cycle aborts with no done
    @(negedge clk);
    start = 1'b1; a = 8'd9; b = 8'd4;
    push_exp(8'h05, 1'b0, 1'b0, cyc + 9);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    void'(sb.pop_back());
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_diff", {24'd0, diff}, 32'd0);
    chk("abort_borrow", {31'd0, borrow}, 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    run_op(8'd9, 8'd4, 8'h05, 1'b0, 1'b0);

    // start held high: done every 9 cycles, busy low only while done
    @(negedge clk);
    start = 1'b1; a = 8'hA5; b = 8'h3C;
    push_exp(8'h69, 1'b0, 1'b1, cyc + 9);
    push_exp(8'h69, 1'b0, 1'b1, cyc + 18);
    push_exp(8'h69, 1'b0, 1'b1, cyc + 27);
    for (int i = 1; i <= 27; i++) begin
      @(negedge clk);
      chk("b2b_busy_xor_done", {31'd0, busy ^ done}, 32'd1);
      if (i == 20) start = 1'b0;
    end

    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    repeat (12) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
